button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//  Consumes the debounced button level from the button debouncer FSM; runs on the same 25 MHz clk.
//  Classifies each press as short, long or double and emits one-cycle pulses to the control logic.
//  One instance per physical button.
// PARAMETERS
//  LONG_CYCLES    25_000_000  hold length (cycles) that makes a press long; >=2
//  GAP_CYCLES     7_500_000   max release gap (cycles) before a second press; >=2
//  REPEAT_CYCLES  5_000_000   auto-repeat period while held long; >=2 (used only with BTN_REPEAT_EN)
// PORTS
//  clk           in   1  25 MHz clock
//  rst           in   1  asynchronous, active-low reset
//  btn_level     in   1  debounced, clean button level (1 = pressed)
//  short_pulse   out  1  one-cycle pulse: single short press
//  long_pulse    out  1  one-cycle pulse: press held LONG_CYCLES
//  double_pulse  out  1  one-cycle pulse: two presses within GAP_CYCLES
//  repeat_pulse  out  1  one-cycle pulse: auto-repeat while long-held
//  busy          out  1  state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, btn_q=1, all outputs 0. A button held through reset release is ignored until seen low.
//  - btn_q: btn_level registered every cycle. rise = btn_level & ~btn_q.
//  - cnt: shared counter, width $clog2(max param + 1), cleared on every state change.
//  - All outputs registered. At most one pulse is high in any cycle. Each pulse lasts exactly one cycle.
//  - IDLE:   rise -> PRESS1.
//  - PRESS1: btn=0 -> GAP.
//            cnt==LONG_CYCLES-1 -> HELD, long_pulse. Release wins if both conditions hold in the same cycle.
//            Otherwise cnt++.
//  - GAP:    btn=1 -> PRESS2. This takes priority over the timeout in the same cycle.
//            cnt==GAP_CYCLES-1 -> IDLE, short_pulse.
//            Otherwise cnt++.
//  - PRESS2: btn=0 -> IDLE, double_pulse.
//            cnt==LONG_CYCLES-1 -> DRAIN, double_pulse.
//            Otherwise cnt++.
//  - HELD:   btn=0 -> IDLE, no pulse.
//            Otherwise repeat counting (see CONFIGURATION).
//  - DRAIN:  btn=0 -> IDLE, no pulse. No outputs are emitted in DRAIN.
//  - Latency: counted in clk edges after the edge that samples the triggering btn_level value.
//      long_pulse rises LONG_CYCLES edges after the press-sampling edge.
//      short_pulse rises GAP_CYCLES edges after the release-sampling edge.
//      double_pulse rises 1 edge after the second release-sampling edge.
//  - Reset asserted mid-operation: immediate return to IDLE, no pending pulse is emitted.
// CONFIGURATION
//  - BTN_REPEAT_EN defined: in HELD, cnt++. At cnt==REPEAT_CYCLES-1, repeat_pulse is asserted and cnt=0.
//    The first repeat_pulse comes REPEAT_CYCLES edges after long_pulse.
//  - BTN_REPEAT_EN undefined: repeat_pulse is tied 0 and cnt holds in HELD. The port list is unchanged.
// STRUCTURE
//  - btn_defs.vh (shared include): 3-bit state encodings (IDLE, PRESS1, GAP, PRESS2, HELD, DRAIN) and
//    default timing constants shared with other button blocks.
//  - Sub-module btn_timer: clearable up-counter with a terminal-count compare (clr, en, limit -> tc).
//    It is instantiated once and shared by all states.
// TESTING (LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3)
//  1. btn high 3 cycles, then low -> short_pulse high for 1 cycle, 4 edges after release is sampled.
//     No other pulse.
//  2. btn high 10 cycles -> long_pulse at edge 8 after the press. Release -> no further pulse, busy drops.
//  3. btn high 2, low 2, high 2, low -> double_pulse 1 edge after the second release. No short_pulse.
//  4. With BTN_REPEAT_EN, btn held 20 cycles -> long_pulse, then repeat_pulse every 3 cycles until release.
//     Without the macro: long_pulse only.
//  5. btn high before and during reset release -> no pulse, stays IDLE. Press after a low -> normal classification.
//  6. Reset asserted in GAP at cnt=2 -> all outputs 0 immediately. No short_pulse after reset is released.

Source files
------------

// File: rtl/button_press_classifier_pkg.sv
// rtl/button_press_classifier_pkg.sv - state encodings and default timing for button blocks
package button_press_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HELD   = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    localparam int DEF_LONG_CYCLES   = 25_000_000;
    localparam int DEF_GAP_CYCLES    = 7_500_000;
    localparam int DEF_REPEAT_CYCLES = 5_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_press_classifier_timer.sv
// rtl/button_press_classifier_timer.sv - clearable up-counter with terminal-count compare
module button_press_classifier_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - short/long/double press classifier
// BTN_REPEAT_EN enables auto-repeat pulses while a long press is held.
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) + 1);

    state_t       r_state;
    state_t       w_next;
    logic         r_btn_q;
    logic         r_short, r_long, r_double, r_repeat, r_dbl_pend;
    logic         w_short, w_long, w_double, w_repeat, w_dbl_pend;
    logic         w_rise, w_en, w_wrap, w_clr, w_tc;
    logic [W-1:0] w_limit;

    assign w_rise = btn_level & ~r_btn_q;

    always_comb begin
        w_limit = W'(LONG_CYCLES - 1);
        if (r_state == ST_GAP)  w_limit = W'(GAP_CYCLES - 1);
        if (r_state == ST_HELD) w_limit = W'(REPEAT_CYCLES - 1);
    end

    always_comb begin
        w_next     = r_state;
        w_short    = 1'b0;
        w_long     = 1'b0;
        w_double   = 1'b0;
        w_repeat   = 1'b0;
        w_dbl_pend = 1'b0;
        w_en       = 1'b0;
        w_wrap     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_rise) w_next = ST_PRESS1;
            ST_PRESS1: begin
                if (!btn_level) w_next = ST_GAP;
                else if (w_tc) begin
                    w_next = ST_HELD;
                    w_long = 1'b1;
                end else w_en = 1'b1;
            end
            ST_GAP: begin
                if (btn_level) w_next = ST_PRESS2;
                else if (w_tc) begin
                    w_next  = ST_IDLE;
                    w_short = 1'b1;
                end else w_en = 1'b1;
            end
            ST_PRESS2: begin
                // Release path reports one edge after the release is sampled.
                if (!btn_level) begin
                    w_next     = ST_IDLE;
                    w_dbl_pend = 1'b1;
                end else if (w_tc) begin
                    w_next   = ST_DRAIN;
                    w_double = 1'b1;
                end else w_en = 1'b1;
            end
            ST_HELD: begin
                if (!btn_level) w_next = ST_IDLE;
`ifdef BTN_REPEAT_EN
                else if (w_tc) begin
                    w_repeat = 1'b1;
                    w_wrap   = 1'b1;
                end else w_en = 1'b1;
`endif
            end
            ST_DRAIN: if (!btn_level) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_clr = (w_next != r_state) | w_wrap;

    button_press_classifier_timer #(.W(W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    // btn_q resets high so a button held through reset is ignored until released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_btn_q    <= 1'b1;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_double   <= 1'b0;
            r_repeat   <= 1'b0;
            r_dbl_pend <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_btn_q    <= btn_level;
            r_short    <= w_short;
            r_long     <= w_long;
            r_double   <= w_double | r_dbl_pend;
            r_repeat   <= w_repeat;
            r_dbl_pend <= w_dbl_pend;
        end
    end

    assign short_pulse  = r_short;
    assign long_pulse   = r_long;
    assign double_pulse = r_double;
    assign repeat_pulse = r_repeat;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - directed self-checking bench for button_press_classifier
module tb_button_press_classifier;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_level = 1'b0;
    logic short_pulse, long_pulse, double_pulse, repeat_pulse, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_short, n_long, n_double, n_repeat;
    int c_short, c_long, c_double, c_repeat_first, c_repeat_last;
    int e0, r1, r2;
    int exp_rep, exp_rep_first, exp_rep_last;

    always #20 clk = ~clk;

    button_press_classifier #(
        .LONG_CYCLES   (8),
        .GAP_CYCLES    (4),
        .REPEAT_CYCLES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_level    (btn_level),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .double_pulse (double_pulse),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_short = 0; n_long = 0; n_double = 0; n_repeat = 0;
        c_short = -1; c_long = -1; c_double = -1; c_repeat_first = -1; c_repeat_last = -1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (short_pulse)  begin n_short++;  c_short  = cyc; end
            if (long_pulse)   begin n_long++;   c_long   = cyc; end
            if (double_pulse) begin n_double++; c_double = cyc; end
            if (repeat_pulse) begin
                n_repeat++;
                if (c_repeat_first < 0) c_repeat_first = cyc;
                c_repeat_last = cyc;
            end
            chk("one_hot_pulses",
                (int'(short_pulse) + int'(long_pulse) + int'(double_pulse) + int'(repeat_pulse)) <= 1, 1);
        end
    endtask

    initial begin
        clear_counts();
        #5;
        chk("reset_outputs", {short_pulse, long_pulse, double_pulse, repeat_pulse}, 0);
        chk("reset_busy", busy, 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // 1: short press
        clear_counts();
        btn_level = 1'b1; tick(3);
        chk("t1_busy_pressed", busy, 1);
        btn_level = 1'b0; tick(1); r1 = cyc;
        tick(6);
        chk("t1_short_count", n_short, 1);
        chk("t1_short_cycle", c_short, r1 + 4);
        chk("t1_other_pulses", n_long + n_double + n_repeat, 0);
        chk("t1_busy_idle", busy, 0);

        // 2: long press, 10 cycles
        clear_counts();
        btn_level = 1'b1; tick(1); e0 = cyc;
        tick(9);
        chk("t2_long_count", n_long, 1);
        chk("t2_long_cycle", c_long, e0 + 8);
        chk("t2_busy_held", busy, 1);
        btn_level = 1'b0; tick(1);
        chk("t2_busy_release", busy, 0);
        tick(6);
        chk("t2_long_total", n_long, 1);
        chk("t2_other_pulses", n_short + n_double + n_repeat, 0);

        // 3: double press
        clear_counts();
        btn_level = 1'b1; tick(2);
        btn_level = 1'b0; tick(2);
        btn_level = 1'b1; tick(2);
        btn_level = 1'b0; tick(1); r2 = cyc;
        tick(7);
        chk("t3_double_count", n_double, 1);
        chk("t3_double_cycle", c_double, r2 + 1);
        chk("t3_no_short", n_short, 0);
        chk("t3_no_long", n_long, 0);
        chk("t3_busy_idle", busy, 0);

        // 4: held 20 cycles
        clear_counts();
        btn_level = 1'b1; tick(1); e0 = cyc;
        tick(19);
        btn_level = 1'b0; tick(5);
`ifdef BTN_REPEAT_EN
        exp_rep = 3; exp_rep_first = e0 + 11; exp_rep_last = e0 + 17;
`else
        exp_rep = 0; exp_rep_first = -1; exp_rep_last = -1;
`endif
        chk("t4_long_count", n_long, 1);
        chk("t4_long_cycle", c_long, e0 + 8);
        chk("t4_repeat_count", n_repeat, exp_rep);
        chk("t4_repeat_first", c_repeat_first, exp_rep_first);
        chk("t4_repeat_last", c_repeat_last, exp_rep_last);
        chk("t4_other_pulses", n_short + n_double, 0);

        // 5: button held through reset release
        clear_counts();
        btn_level = 1'b1;
        rst = 1'b0; tick(2);
        rst = 1'b1; tick(12);
        chk("t5_held_no_pulse", n_short + n_long + n_double + n_repeat, 0);
        chk("t5_held_idle", busy, 0);
        btn_level = 1'b0; tick(2);
        btn_level = 1'b1; tick(3);
        btn_level = 1'b0; tick(1); r1 = cyc;
        tick(6);
        chk("t5_short_count", n_short, 1);
        chk("t5_short_cycle", c_short, r1 + 4);

        // 6: reset in GAP at cnt=2
        clear_counts();
        btn_level = 1'b1; tick(2);
        btn_level = 1'b0; tick(3);
        chk("t6_busy_gap", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_outputs_async", {short_pulse, long_pulse, double_pulse, repeat_pulse}, 0);
        chk("t6_busy_async", busy, 0);
        tick(2);
        rst = 1'b1; tick(8);
        chk("t6_no_short", n_short + n_long + n_double + n_repeat, 0);
        chk("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
